// File: rtl/priority_scan_encoder.sv
// Sequential priority encoder: emits the index of every set bit of an
// accepted request vector, one beat per handshake, in priority order.
`timescale 1ns/1ps
module priority_scan_encoder #(
    parameter int WIDTH     = 8,
    parameter int IDX_W     = 3,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic [IDX_W:0]   out_cnt,
    output logic             busy
);

    generate
        if (WIDTH < 2 || WIDTH > 256) begin : g_bad_width
            $error("priority_scan_encoder: WIDTH out of range 2..256");
        end
        if (IDX_W != $clog2(WIDTH)) begin : g_bad_idx_w
            $error("priority_scan_encoder: IDX_W must equal clog2(WIDTH)");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        NONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IDX_W:0]   cnt_q, cnt_d;

    logic [IDX_W-1:0] pri_idx;
    logic             pri_found;
    logic             one_left;
    logic [IDX_W:0]   vec_pop;
    logic             accept;

    // Population count of the incoming vector, latched only on accept.
    always_comb begin
        vec_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            vec_pop = vec_pop + {{IDX_W{1'b0}}, in_vec[i]};
        end
    end

    always_comb begin
        pri_idx   = '0;
        pri_found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pending_q[i]) begin
                if (!LSB_FIRST || !pri_found) begin
                    pri_idx = IDX_W'(i);
                end
                pri_found = 1'b1;
            end
        end
    end

    // Exactly one bit set: clearing the lowest set bit leaves nothing.
    assign one_left = (pending_q != '0) &&
                      ((pending_q & (pending_q - WIDTH'(1))) == '0);

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_vec != '0) begin
                        pending_d = in_vec;
                        cnt_d     = vec_pop;
                        state_d   = SCAN;
                    end else begin
                        cnt_d   = '0;
                        state_d = NONE;
                    end
                end
            end
            SCAN: begin
                if (!en) begin
                    pending_d = '0;
                    state_d   = IDLE;
                end else if (out_ready) begin
                    pending_d[pri_idx] = 1'b0;
                    if (one_left) begin
                        state_d = IDLE;
                    end
                end
            end
            NONE: begin
                if (!en || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                pending_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = rst_n && en && (state_q == IDLE);
        out_valid = (state_q == SCAN) || (state_q == NONE);
        out_idx   = (state_q == SCAN) ? pri_idx : '0;
        out_last  = ((state_q == SCAN) && one_left) ||
                    (state_q == NONE);
        out_none  = (state_q == NONE);
        out_cnt   = cnt_q;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Scoreboard bench for priority_scan_encoder: MSB-first, LSB-first and
// 16-bit instances; expected beats queued by stimulus, checked by monitors.
`timescale 1ns/1ps
module tb_priority_scan_encoder;

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
        logic       none;
        logic [4:0] cnt;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    logic       a_iv, a_ir, a_ov, a_or, a_last, a_none, a_busy;
    logic [7:0] a_vec;
    logic [2:0] a_idx;
    logic [3:0] a_cnt;

    logic       b_iv, b_ir, b_ov, b_or, b_last, b_none, b_busy;
    logic [7:0] b_vec;
    logic [2:0] b_idx;
    logic [3:0] b_cnt;

    logic        c_iv, c_ir, c_ov, c_or, c_last, c_none, c_busy;
    logic [15:0] c_vec;
    logic [3:0]  c_idx;
    logic [4:0]  c_cnt;

    beat_t q0[$];
    beat_t q1[$];
    beat_t q2[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    priority_scan_encoder #(.WIDTH(8), .IDX_W(3), .LSB_FIRST(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(a_iv), .in_ready(a_ir), .in_vec(a_vec),
        .out_valid(a_ov), .out_ready(a_or), .out_idx(a_idx),
        .out_last(a_last), .out_none(a_none), .out_cnt(a_cnt),
        .busy(a_busy)
    );

    priority_scan_encoder #(.WIDTH(8), .IDX_W(3), .LSB_FIRST(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(b_iv), .in_ready(b_ir), .in_vec(b_vec),
        .out_valid(b_ov), .out_ready(b_or), .out_idx(b_idx),
        .out_last(b_last), .out_none(b_none), .out_cnt(b_cnt),
        .busy(b_busy)
    );

    priority_scan_encoder #(.WIDTH(16), .IDX_W(4), .LSB_FIRST(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(c_iv), .in_ready(c_ir), .in_vec(c_vec),
        .out_valid(c_ov), .out_ready(c_or), .out_idx(c_idx),
        .out_last(c_last), .out_none(c_none), .out_cnt(c_cnt),
        .busy(c_busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int d, input int idx, input int last,
                        input int none, input int cnt);
        beat_t e;
        e.idx  = 4'(idx);
        e.last = 1'(last);
        e.none = 1'(none);
        e.cnt  = 5'(cnt);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mon(input int d, input logic ov, input logic ordy,
                       input logic [3:0] idx, input logic last,
                       input logic none, input logic [4:0] cnt);
        beat_t e;
        int    sz;
        case (d)
            0: sz = q0.size();
            1: sz = q1.size();
            default: sz = q2.size();
        endcase
        if (!ov) begin
            chk($sformatf("dut%0d idle_outs", d), {idx, last, none}, 0);
        end else if (sz == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dut%0d unexpected beat idx=%0d last=%0d none=%0d",
                     d, idx, last, none);
        end else begin
            case (d)
                0: e = q0[0];
                1: e = q1[0];
                default: e = q2[0];
            endcase
            chk($sformatf("dut%0d idx", d), idx, e.idx);
            chk($sformatf("dut%0d last", d), last, e.last);
            chk($sformatf("dut%0d none", d), none, e.none);
            chk($sformatf("dut%0d cnt", d), cnt, e.cnt);
            if (ordy) begin
                case (d)
                    0: void'(q0.pop_front());
                    1: void'(q1.pop_front());
                    default: void'(q2.pop_front());
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_ov, a_or, {1'b0, a_idx}, a_last, a_none, {1'b0, a_cnt});
        mon(1, b_ov, b_or, {1'b0, b_idx}, b_last, b_none, {1'b0, b_cnt});
        mon(2, c_ov, c_or, c_idx, c_last, c_none, c_cnt);
    end

    task automatic drive(input int d, input logic v, input logic [15:0] vec,
                         input logic ordy);
        case (d)
            0: begin a_iv = v; a_vec = vec[7:0]; a_or = ordy; end
            1: begin b_iv = v; b_vec = vec[7:0]; b_or = ordy; end
            default: begin c_iv = v; c_vec = vec; c_or = ordy; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        drive(0, 1'b0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 1'b0);
        drive(2, 1'b0, 16'h0, 1'b0);

        @(negedge clk);
        chk("rst a_ov", a_ov, 0);
        chk("rst a_busy", a_busy, 0);
        chk("rst a_ir", a_ir, 0);
        chk("rst a_cnt", a_cnt, 0);
        chk("rst b_ir", b_ir, 0);
        chk("rst c_ir", c_ir, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("a_ir after reset", a_ir, 1);

        // MSB-first scan of 1010_0110
        tick();
        push(0, 7, 0, 0, 4);
        push(0, 5, 0, 0, 4);
        push(0, 2, 0, 0, 4);
        push(0, 1, 1, 0, 4);
        drive(0, 1'b1, 16'h00A6, 1'b1);
        tick();
        drive(0, 1'b0, 16'h0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t1 ov beat%0d", k), a_ov, 1);
            chk($sformatf("t1 ir beat%0d", k), a_ir, 0);
            tick();
        end
        @(negedge clk);
        chk("t1 ov after", a_ov, 0);
        chk("t1 ir after", a_ir, 1);

        // LSB-first scan, then all-zero vector
        tick();
        push(1, 1, 0, 0, 4);
        push(1, 2, 0, 0, 4);
        push(1, 5, 0, 0, 4);
        push(1, 7, 1, 0, 4);
        drive(1, 1'b1, 16'h00A6, 1'b1);
        tick();
        drive(1, 1'b0, 16'h0, 1'b1);
        repeat (4) tick();
        @(negedge clk);
        chk("t2 ov after", b_ov, 0);
        tick();
        push(1, 0, 1, 1, 0);
        drive(1, 1'b1, 16'h0000, 1'b1);
        tick();
        drive(1, 1'b0, 16'h0, 1'b1);
        @(negedge clk);
        chk("t2 none ov", b_ov, 1);
        tick();
        @(negedge clk);
        chk("t2 none done", b_ov, 0);

        // Backpressure with in_valid held during the scan
        tick();
        push(0, 7, 0, 0, 2);
        push(0, 0, 1, 0, 2);
        drive(0, 1'b1, 16'h0081, 1'b0);
        tick();
        drive(0, 1'b1, 16'h0001, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t3 stall ir%0d", k), a_ir, 0);
            chk($sformatf("t3 stall ov%0d", k), a_ov, 1);
            tick();
        end
        drive(0, 1'b0, 16'h0, 1'b1);
        repeat (2) tick();
        @(negedge clk);
        chk("t3 ov after", a_ov, 0);
        repeat (2) tick();
        @(negedge clk);
        chk("t3 no extra accept", a_ov, 0);

        // Abort with en after two beats
        tick();
        push(0, 7, 0, 0, 8);
        push(0, 6, 0, 0, 8);
        drive(0, 1'b1, 16'h00FF, 1'b1);
        tick();
        drive(0, 1'b0, 16'h0, 1'b1);
        tick();
        en = 1'b0;
        tick();
        @(negedge clk);
        chk("t4 ov aborted", a_ov, 0);
        chk("t4 busy aborted", a_busy, 0);
        chk("t4 ir en low", a_ir, 0);
        chk("t4 cnt kept", a_cnt, 8);
        tick();
        @(negedge clk);
        chk("t4 no more beats", a_ov, 0);
        tick();
        en = 1'b1;
        push(0, 4, 1, 0, 1);
        drive(0, 1'b1, 16'h0010, 1'b1);
        tick();
        drive(0, 1'b0, 16'h0, 1'b1);
        @(negedge clk);
        chk("t4 next ov", a_ov, 1);
        tick();
        @(negedge clk);
        chk("t4 next done", a_ov, 0);

        // Asynchronous reset in the middle of a scan
        tick();
        push(0, 7, 0, 0, 4);
        drive(0, 1'b1, 16'h00A6, 1'b1);
        tick();
        drive(0, 1'b0, 16'h0, 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 ov in reset", a_ov, 0);
        chk("t5 busy in reset", a_busy, 0);
        chk("t5 ir in reset", a_ir, 0);
        chk("t5 cnt in reset", a_cnt, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5 ir after release", a_ir, 1);
        chk("t5 ov after release", a_ov, 0);

        // 16-bit instance, out_ready toggling 1,0,1
        tick();
        push(2, 15, 0, 0, 2);
        push(2, 0, 1, 0, 2);
        drive(2, 1'b1, 16'h8001, 1'b1);
        tick();
        drive(2, 1'b0, 16'h0, 1'b1);
        tick();
        drive(2, 1'b0, 16'h0, 1'b0);
        tick();
        drive(2, 1'b0, 16'h0, 1'b1);
        tick();
        @(negedge clk);
        chk("t6 ov after", c_ov, 0);

        chk("q0 drained", q0.size(), 0);
        chk("q1 drained", q1.size(), 0);
        chk("q2 drained", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
